sprite_fetch_sequencer: RTL and testbench
=========================================

// Module: sprite_fetch_sequencer
// PURPOSE
//  Upstream neighbour of the sprite pixel shifter. Accepts one sprite-fetch request per matched OAM entry and reads its
//  tile-row low and high plane bytes from VRAM (8x8 or 8x16 sprites, Y flip).
//  Applies X flip and computes the transparency merge mask, then issues a one-cycle parallel load into the two sprite
//  pixel shift registers and their attribute shifters.
// PARAMETERS
//  VRAM_AW      13     VRAM byte address width (0x0000-0x1FFF, sprite tiles at 0x0000-0x0FFF)
//  RD_WAIT      2      cycles each VRAM read is held before data is captured (>=1)
// PORTS
//  clk          in   1   pipeline clock; all state changes on rising edge
//  reset        in   1   asynchronous, active-high; clears all state
//  fetch_req    in   1   request; sampled only when busy=0
//  tile_num     in   8   OAM tile index
//  row          in   4   line offset within sprite (ly - oam_y + 16), bits [3:0]
//  attr         in   8   OAM attribute byte: [7]=priority, [6]=yflip, [5]=xflip, [4]=palette
//  tall         in   1   LCDC.2: 1 = 8x16 sprites
//  abort        in   1   cancel any fetch in progress (line end / mode change)
//  md           in   8   VRAM read data bus
//  occ_a,occ_b  in   8   current sprite shifter contents, plane A/B (bit7 = next pixel out)
//  busy         out  1   high from accept until returning to IDLE
//  vram_addr    out  13  VRAM byte address
//  vram_rd      out  1   VRAM read strobe
//  load_en      out  1   one-cycle parallel-load strobe to the shifters
//  load_mask    out  8   1 = shifter position takes new pixel (position currently transparent)
//  spr_lo,spr_hi out 8   plane bytes after X flip (bit7 = leftmost pixel)
//  spr_pal,spr_pri out 1 attribute bits for attribute shifters, loaded under load_mask
//  done         out  1   one-cycle pulse coincident with load_en
// BEHAVIOUR
//  Reset: state=IDLE; busy, vram_rd, load_en, done=0; vram_addr, load_mask, spr_lo, spr_hi=0; spr_pal, spr_pri=0.
//  States: IDLE -> LO (RD_WAIT cycles) -> HI (RD_WAIT cycles) -> LOAD (1 cycle) -> IDLE.
//  IDLE: when fetch_req=1 at an edge, register tile_num, row, attr and tall, then go to LO. busy=1 from the next cycle.
//  Row select: r = yflip ? (tall ? 15-row : 7-row[2:0]) : row. For 8x8, row[3] is ignored.
//  Tile select: t = tall ? {tile_num[7:1], r[3]} : tile_num.
//  Address: lo = {t, r[2:0], 1'b0}; hi = lo | 1. Width is 12 bits, zero-extended to VRAM_AW.
//  LO: vram_addr = lo, vram_rd=1; on the last LO cycle, capture md into lo_q. HI: same with hi, capture into hi_q.
//  LOAD: load_en=1, done=1, vram_rd=0.
//   spr_lo/spr_hi = xflip ? bitrev(lo_q/hi_q) : lo_q/hi_q. load_mask = ~(occ_a | occ_b), sampled in this cycle.
//   spr_pal/spr_pri come from the registered attr.
//  Outputs are registered, except load_mask, which is combinational from occ_* during LOAD and 0 otherwise.
//  Latency: accept edge to load_en = 2*RD_WAIT+1 cycles (5 with default). Back-to-back: fetch_req is re-sampled
//   on the LOAD->IDLE edge+1, giving a minimum period of 2*RD_WAIT+2 cycles.
//  abort=1 in any non-IDLE state: next state is IDLE, no load_en/done, captured bytes discarded.
//   abort in LOAD cycle: load_en is suppressed combinationally.
//  abort with fetch_req in IDLE: the request is ignored.
//  Changes to tile_num, row or attr after accept have no effect. Reset mid-fetch: immediate return to IDLE,
//   no load emitted.
//  Full mask (0xFF) and empty mask (0x00) are legal. A 0x00 mask still pulses load_en and done.
// STRUCTURE
//  Package ppu_sprite_pkg: state enum (IDLE,LO,HI,LOAD), OAM attr bit indices, SPR_TILE_BASE constant.
//  Sub-module sprite_row_addr: combinational {tile_num,row,yflip,tall} -> {lo,hi} address.
//  Bit reverse and mask are inline.
// TESTING
//  1. 8x8, tile 0x42, row 3, attr 0x00; md=0xA5 then 0x3C.
//     -> addr 0x426 then 0x427; load_en at cycle 5; spr_lo=0xA5, spr_hi=0x3C.
//  2. 8x16, tile 0x43, row 12, yflip=1 -> t=0x42, r=3 -> addr 0x426/0x427.
//     row 2 yflip -> r=13 -> t=0x43 -> addr 0x43A/0x43B.
//  3. xflip=1, md lo=0x80, hi=0x03 -> spr_lo=0x01, spr_hi=0xC0.
//  4. occ_a=0x0F, occ_b=0x30 during LOAD -> load_mask=0xC0. occ all 0 -> 0xFF; occ_a=0xFF -> 0x00 with load_en=1.
//  5. abort during HI -> IDLE next cycle, no load_en/done. Reset asserted in LO -> all outputs 0 asynchronously.
//  6. fetch_req held high continuously -> loads every 6 cycles. Inputs changed mid-fetch do not alter vram_addr.

Source files
------------

// File: rtl/sprite_fetch_sequencer_pkg.sv
// Shared types and constants for the sprite fetch sequencer.
package sprite_fetch_sequencer_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_LOAD = 2'd3
  } state_t;

  // OAM attribute byte bit positions
  localparam int ATTR_PRI   = 7;
  localparam int ATTR_YFLIP = 6;
  localparam int ATTR_XFLIP = 5;
  localparam int ATTR_PAL   = 4;

  // Sprite tiles live at the bottom of VRAM
  localparam logic [15:0] SPR_TILE_BASE = 16'h0000;

endpackage

// File: rtl/sprite_fetch_sequencer_if.sv
// Request/VRAM/shifter-load bundle between the sprite fetcher and its neighbours.
interface sprite_fetch_sequencer_if #(
  parameter int VRAM_AW = 13
);
  logic               fetch_req;
  logic [7:0]         tile_num;
  logic [3:0]         row;
  logic [7:0]         attr;
  logic               tall;
  logic               abort;
  logic [7:0]         md;
  logic [7:0]         occ_a;
  logic [7:0]         occ_b;

  logic               busy;
  logic [VRAM_AW-1:0] vram_addr;
  logic               vram_rd;
  logic               load_en;
  logic [7:0]         load_mask;
  logic [7:0]         spr_lo;
  logic [7:0]         spr_hi;
  logic               spr_pal;
  logic               spr_pri;
  logic               done;

  // Requester / VRAM / shifter side
  modport master (
    output fetch_req, tile_num, row, attr, tall, abort, md, occ_a, occ_b,
    input  busy, vram_addr, vram_rd, load_en, load_mask, spr_lo, spr_hi,
           spr_pal, spr_pri, done
  );

  // Fetch sequencer side
  modport slave (
    input  fetch_req, tile_num, row, attr, tall, abort, md, occ_a, occ_b,
    output busy, vram_addr, vram_rd, load_en, load_mask, spr_lo, spr_hi,
           spr_pal, spr_pri, done
  );
endinterface

// File: rtl/sprite_fetch_sequencer_row_addr.sv
// Tile-row byte address for a sprite: handles Y flip and 8x16 tile pairing.
module sprite_fetch_sequencer_row_addr
  import sprite_fetch_sequencer_pkg::*;
#(
  parameter int VRAM_AW = 13
) (
  input  logic [7:0]         i_tile_num,
  input  logic [3:0]         i_row,
  input  logic               i_yflip,
  input  logic               i_tall,
  output logic [VRAM_AW-1:0] o_lo,
  output logic [VRAM_AW-1:0] o_hi
);

  logic [3:0]  w_r;
  logic [7:0]  w_t;
  logic [11:0] w_lo12;

  // Row flip, tile pairing (row bit 3 picks the lower/upper tile in 8x16) and byte address
  always_comb begin
    w_r = i_row;
    if (i_yflip) begin
      w_r = i_tall ? (4'd15 - i_row) : {1'b0, 3'd7 - i_row[2:0]};
    end
    w_t    = i_tall ? {i_tile_num[7:1], w_r[3]} : i_tile_num;
    w_lo12 = {w_t, w_r[2:0], 1'b0};
    o_lo   = VRAM_AW'(SPR_TILE_BASE) | VRAM_AW'(w_lo12);
    o_hi   = o_lo | VRAM_AW'(1);
  end

endmodule

// File: rtl/sprite_fetch_sequencer.sv
// Sprite fetch sequencer: reads one sprite tile row (low then high plane) from VRAM,
// applies X flip and issues a one-cycle parallel load into the sprite shifters.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  IDLE    | waiting for fetch_req; address path follows live inputs
//  LO      | low-plane read held RD_WAIT cycles, captured on last one
//  HI      | high-plane read held RD_WAIT cycles, captured on last one
//  LOAD    | load_en/done pulse, mask taken from live shifter occupancy
module sprite_fetch_sequencer
  import sprite_fetch_sequencer_pkg::*;
#(
  parameter int VRAM_AW = 13,
  parameter int RD_WAIT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  sprite_fetch_sequencer_if.slave  bus
);

  localparam int           WW        = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_INIT = WW'(RD_WAIT - 1);

  state_t             r_state;
  logic [WW-1:0]      r_wait;
  logic [7:0]         r_tile;
  logic [3:0]         r_row;
  logic               r_tall;
  logic               r_yflip;
  logic               r_xflip;
  logic               r_pal;
  logic               r_pri;
  logic [7:0]         r_lo_q;
  logic               r_busy;
  logic               r_vram_rd;
  logic               r_load;
  logic [VRAM_AW-1:0] r_vram_addr;
  logic [7:0]         r_spr_lo;
  logic [7:0]         r_spr_hi;
  logic               r_spr_pal;
  logic               r_spr_pri;

  logic               w_is_idle;
  logic               w_wait_tc;
  logic [7:0]         w_tile;
  logic [3:0]         w_row;
  logic               w_tall;
  logic               w_yflip;
  logic [VRAM_AW-1:0] w_lo_addr;
  logic [VRAM_AW-1:0] w_hi_addr;
  logic [7:0]         w_lo_rev;
  logic [7:0]         w_hi_rev;
  logic [3:0]         w_attr_unused;

  assign w_is_idle     = (r_state == ST_IDLE);
  assign w_wait_tc     = (r_wait == '0);
  assign w_attr_unused = bus.attr[3:0];

  // In IDLE the address is built from the live request so the first read address
  // can be registered on the accept edge; afterwards the latched copy is used.
  assign w_tile  = w_is_idle ? bus.tile_num           : r_tile;
  assign w_row   = w_is_idle ? bus.row                : r_row;
  assign w_tall  = w_is_idle ? bus.tall               : r_tall;
  assign w_yflip = w_is_idle ? bus.attr[ATTR_YFLIP]   : r_yflip;

  sprite_fetch_sequencer_row_addr #(
    .VRAM_AW (VRAM_AW)
  ) u_row_addr (
    .i_tile_num (w_tile),
    .i_row      (w_row),
    .i_yflip    (w_yflip),
    .i_tall     (w_tall),
    .o_lo       (w_lo_addr),
    .o_hi       (w_hi_addr)
  );

  // Bit-reversed plane bytes for X flip (high plane comes straight off the bus)
  always_comb begin
    w_lo_rev = '0;
    w_hi_rev = '0;
    for (int i = 0; i < 8; i++) begin
      w_lo_rev[i] = r_lo_q[7-i];
      w_hi_rev[i] = bus.md[7-i];
    end
  end

  // Sequencer state, read timing and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wait      <= '0;
      r_tile      <= '0;
      r_row       <= '0;
      r_tall      <= 1'b0;
      r_yflip     <= 1'b0;
      r_xflip     <= 1'b0;
      r_pal       <= 1'b0;
      r_pri       <= 1'b0;
      r_lo_q      <= '0;
      r_busy      <= 1'b0;
      r_vram_rd   <= 1'b0;
      r_load      <= 1'b0;
      r_vram_addr <= '0;
      r_spr_lo    <= '0;
      r_spr_hi    <= '0;
      r_spr_pal   <= 1'b0;
      r_spr_pri   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_load <= 1'b0;
          if (bus.fetch_req && !bus.abort) begin
            r_tile      <= bus.tile_num;
            r_row       <= bus.row;
            r_tall      <= bus.tall;
            r_yflip     <= bus.attr[ATTR_YFLIP];
            r_xflip     <= bus.attr[ATTR_XFLIP];
            r_pal       <= bus.attr[ATTR_PAL];
            r_pri       <= bus.attr[ATTR_PRI];
            r_wait      <= WAIT_INIT;
            r_busy      <= 1'b1;
            r_vram_rd   <= 1'b1;
            r_vram_addr <= w_lo_addr;
            r_state     <= ST_LO;
          end
        end
        ST_LO: begin
          if (bus.abort) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_vram_rd <= 1'b0;
          end else if (w_wait_tc) begin
            r_lo_q      <= bus.md;
            r_wait      <= WAIT_INIT;
            r_vram_addr <= w_hi_addr;
            r_state     <= ST_HI;
          end else begin
            r_wait <= r_wait - WW'(1);
          end
        end
        ST_HI: begin
          if (bus.abort) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_vram_rd <= 1'b0;
          end else if (w_wait_tc) begin
            r_spr_lo  <= r_xflip ? w_lo_rev : r_lo_q;
            r_spr_hi  <= r_xflip ? w_hi_rev : bus.md;
            r_spr_pal <= r_pal;
            r_spr_pri <= r_pri;
            r_vram_rd <= 1'b0;
            r_load    <= 1'b1;
            r_state   <= ST_LOAD;
          end else begin
            r_wait <= r_wait - WW'(1);
          end
        end
        ST_LOAD: begin
          r_load  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_vram_rd <= 1'b0;
          r_load    <= 1'b0;
        end
      endcase
    end
  end

  // A late abort in the LOAD cycle must still kill the strobe, hence the gating here.
  assign bus.load_en   = r_load & ~bus.abort;
  assign bus.done      = r_load & ~bus.abort;
  assign bus.load_mask = (r_state == ST_LOAD) ? ~(bus.occ_a | bus.occ_b) : 8'h00;
  assign bus.busy      = r_busy;
  assign bus.vram_rd   = r_vram_rd;
  assign bus.vram_addr = r_vram_addr;
  assign bus.spr_lo    = r_spr_lo;
  assign bus.spr_hi    = r_spr_hi;
  assign bus.spr_pal   = r_spr_pal;
  assign bus.spr_pri   = r_spr_pri;

endmodule

// File: tb/tb_sprite_fetch_sequencer.sv
// Directed bench for sprite_fetch_sequencer with a two-byte VRAM model.
module tb_sprite_fetch_sequencer;

  logic clk;
  logic reset;
  logic [7:0] vram_lo;
  logic [7:0] vram_hi;
  int errors;
  int checks;

  sprite_fetch_sequencer_if #(.VRAM_AW(13)) bus ();

  sprite_fetch_sequencer #(
    .VRAM_AW (13),
    .RD_WAIT (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM returns the low-plane byte at even addresses, high-plane at odd ones
  assign bus.md = !bus.vram_rd ? 8'hEE : (bus.vram_addr[0] ? vram_hi : vram_lo);

  task automatic do_fetch(input logic [7:0] tile, input logic [3:0] rw, input logic [7:0] at,
                          input logic tl, input logic [7:0] lo_b, input logic [7:0] hi_b,
                          input logic [12:0] exp_a, input logic [7:0] exp_lo, input logic [7:0] exp_hi,
                          input logic [7:0] oa, input logic [7:0] ob, input logic [7:0] exp_mask,
                          input string nm);
    int n;
    bus.tile_num = tile; bus.row = rw; bus.attr = at; bus.tall = tl;
    bus.occ_a = oa; bus.occ_b = ob; vram_lo = lo_b; vram_hi = hi_b;
    bus.fetch_req = 1'b1;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    n = 1;
    bus.tile_num = tile ^ 8'hFF; bus.row = rw ^ 4'hF; bus.attr = at ^ 8'hFF;
    checks++;
    if (bus.vram_addr !== exp_a || bus.vram_rd !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s addr_lo: addr=%h rd=%b busy=%b, required addr=%h rd=1 busy=1",
               nm, bus.vram_addr, bus.vram_rd, bus.busy, exp_a);
    end
    while (bus.load_en !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
      if (n == 3) begin
        checks++;
        if (bus.vram_addr !== (exp_a | 13'h1) || bus.vram_rd !== 1'b1) begin
          errors++;
          $display("FAIL %s addr_hi: addr=%h rd=%b, required addr=%h rd=1",
                   nm, bus.vram_addr, bus.vram_rd, exp_a | 13'h1);
        end
      end
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL %s latency: load_en at cycle %0d, required 5", nm, n);
    end
    checks++;
    if (bus.spr_lo !== exp_lo || bus.spr_hi !== exp_hi || bus.done !== 1'b1 ||
        bus.load_mask !== exp_mask || bus.spr_pal !== at[4] || bus.spr_pri !== at[7] ||
        bus.vram_rd !== 1'b0) begin
      errors++;
      $display("FAIL %s load: lo=%h hi=%h done=%b mask=%h pal=%b pri=%b rd=%b, required lo=%h hi=%h done=1 mask=%h pal=%b pri=%b rd=0",
               nm, bus.spr_lo, bus.spr_hi, bus.done, bus.load_mask, bus.spr_pal, bus.spr_pri,
               bus.vram_rd, exp_lo, exp_hi, exp_mask, at[4], at[7]);
    end
    @(negedge clk);
    checks++;
    if (bus.load_en !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.load_mask !== 8'h00) begin
      errors++;
      $display("FAIL %s idle_after: load_en=%b done=%b busy=%b mask=%h, required 0 0 0 00",
               nm, bus.load_en, bus.done, bus.busy, bus.load_mask);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.fetch_req = 1'b0; bus.tile_num = '0; bus.row = '0; bus.attr = '0; bus.tall = 1'b0;
    bus.abort = 1'b0; bus.occ_a = '0; bus.occ_b = '0; vram_lo = '0; vram_hi = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.vram_rd !== 1'b0 || bus.load_en !== 1'b0 || bus.done !== 1'b0 ||
        bus.vram_addr !== 13'h0 || bus.load_mask !== 8'h00 || bus.spr_lo !== 8'h00 ||
        bus.spr_hi !== 8'h00 || bus.spr_pal !== 1'b0 || bus.spr_pri !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rd=%b load=%b done=%b addr=%h mask=%h lo=%h hi=%h pal=%b pri=%b, required all zero",
               bus.busy, bus.vram_rd, bus.load_en, bus.done, bus.vram_addr, bus.load_mask,
               bus.spr_lo, bus.spr_hi, bus.spr_pal, bus.spr_pri);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_8x8();
    do_fetch(8'h42, 4'd3, 8'h00, 1'b0, 8'hA5, 8'h3C, 13'h426, 8'hA5, 8'h3C, 8'h00, 8'h00, 8'hFF, "basic");
    do_fetch(8'h10, 4'd11, 8'h00, 1'b0, 8'h11, 8'h22, 13'h106, 8'h11, 8'h22, 8'h00, 8'h00, 8'hFF, "row3_ignored");
    do_fetch(8'h10, 4'd3, 8'h40, 1'b0, 8'h5A, 8'hC3, 13'h108, 8'h5A, 8'hC3, 8'h00, 8'h00, 8'hFF, "yflip_8x8");
  endtask

  task automatic test_tall();
    do_fetch(8'h43, 4'd12, 8'h40, 1'b1, 8'h01, 8'h02, 13'h426, 8'h01, 8'h02, 8'h00, 8'h00, 8'hFF, "tall_yflip_r3");
    do_fetch(8'h43, 4'd2, 8'h40, 1'b1, 8'h04, 8'h08, 13'h43A, 8'h04, 8'h08, 8'h00, 8'h00, 8'hFF, "tall_yflip_r13");
    do_fetch(8'h42, 4'd9, 8'h00, 1'b1, 8'h77, 8'h88, 13'h432, 8'h77, 8'h88, 8'h00, 8'h00, 8'hFF, "tall_lower");
  endtask

  task automatic test_xflip();
    do_fetch(8'h05, 4'd0, 8'h20, 1'b0, 8'h80, 8'h03, 13'h050, 8'h01, 8'hC0, 8'h00, 8'h00, 8'hFF, "xflip");
    do_fetch(8'h05, 4'd7, 8'h90, 1'b0, 8'h80, 8'h03, 13'h05E, 8'h80, 8'h03, 8'h00, 8'h00, 8'hFF, "pal_pri");
  endtask

  task automatic test_mask();
    do_fetch(8'h20, 4'd1, 8'h00, 1'b0, 8'hF0, 8'h0F, 13'h202, 8'hF0, 8'h0F, 8'h0F, 8'h30, 8'hC0, "mask_c0");
    do_fetch(8'h20, 4'd1, 8'h00, 1'b0, 8'hF0, 8'h0F, 13'h202, 8'hF0, 8'h0F, 8'hFF, 8'h00, 8'h00, "mask_empty");
    bus.occ_a = 8'h00; bus.occ_b = 8'h00;
  endtask

  task automatic test_abort();
    bit saw_load;
    // abort while the high plane is being read
    bus.tile_num = 8'h30; bus.row = 4'd0; bus.attr = 8'h00; bus.tall = 1'b0;
    bus.fetch_req = 1'b1;
    @(negedge clk); bus.fetch_req = 1'b0;
    repeat (2) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.vram_rd !== 1'b0) begin
      errors++;
      $display("FAIL abort_hi: busy=%b rd=%b, required 0 0", bus.busy, bus.vram_rd);
    end
    saw_load = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.load_en !== 1'b0 || bus.done !== 1'b0) saw_load = 1'b1;
    end
    checks++;
    if (saw_load) begin
      errors++;
      $display("FAIL abort_no_load: load_en/done pulsed after abort, required none");
    end
    // abort raised only during the LOAD cycle
    bus.fetch_req = 1'b1;
    @(negedge clk); bus.fetch_req = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 bus.abort = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.load_en !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_load: load_en=%b done=%b, required 0 0", bus.load_en, bus.done);
    end
    bus.abort = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.load_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_load_idle: busy=%b load_en=%b, required 0 0", bus.busy, bus.load_en);
    end
    // abort together with a request in IDLE
    bus.fetch_req = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.fetch_req = 1'b0; bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.vram_rd !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle_req: busy=%b rd=%b, required 0 0", bus.busy, bus.vram_rd);
    end
  endtask

  task automatic test_reset_midfetch();
    bit bad;
    bus.tile_num = 8'h42; bus.row = 4'd3; bus.attr = 8'h00; bus.tall = 1'b0;
    bus.fetch_req = 1'b1;
    @(negedge clk); bus.fetch_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.vram_rd !== 1'b0 || bus.vram_addr !== 13'h0 ||
        bus.spr_lo !== 8'h00 || bus.spr_hi !== 8'h00 || bus.load_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: busy=%b rd=%b addr=%h lo=%h hi=%h load=%b, required all zero",
               bus.busy, bus.vram_rd, bus.vram_addr, bus.spr_lo, bus.spr_hi, bus.load_en);
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.load_en !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_no_load: activity after mid-fetch reset, required none");
    end
  endtask

  task automatic test_back_to_back();
    int loads[$];
    bus.tile_num = 8'h42; bus.row = 4'd3; bus.attr = 8'h00; bus.tall = 1'b0;
    vram_lo = 8'h12; vram_hi = 8'h34;
    bus.fetch_req = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (bus.load_en === 1'b1) loads.push_back(n);
    end
    bus.fetch_req = 1'b0;
    checks++;
    if (loads.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: %0d loads, required 3", loads.size());
    end else begin
      checks++;
      if (loads[0] != 5 || loads[1] != 11 || loads[2] != 17) begin
        errors++;
        $display("FAIL b2b_period: loads at %0d %0d %0d, required 5 11 17", loads[0], loads[1], loads[2]);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: busy=%b, required 0", bus.busy);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic_8x8();
    test_tall();
    test_xflip();
    test_mask();
    test_abort();
    test_reset_midfetch();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
